// File: rtl/mrd_rdx3_feeder.sv
// Frame buffer feeding the radix-3 butterfly: collects 3*N_GRP samples, tracks block-floating-point
// headroom, then replays the frame as N_GRP groups {x[k], x[k+N_GRP], x[k+2*N_GRP]}.
module mrd_rdx3_feeder #(
  parameter int unsigned N_GRP = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_val,
  output logic               in_rdy,
  input  logic signed [17:0] din_real,
  input  logic signed [17:0] din_imag,
  input  logic [3:0]         exp_in,
  output logic               out_val,
  output logic signed [17:0] dout_real [0:4],
  output logic signed [17:0] dout_imag [0:4],
  output logic [1:0]         margin_out,
  output logic [3:0]         exp_out
);

  localparam int unsigned Frame = 3 * N_GRP;
  localparam int unsigned WrW   = $clog2(Frame);
  localparam int unsigned RdW   = $clog2(N_GRP);

  typedef enum logic {StFill, StDrain} state_e;

  state_e state_q, state_d;

  logic [WrW-1:0]     wr_cnt_q;
  logic [RdW-1:0]     rd_cnt_q;
  logic [1:0]         run_min_q;
  logic [1:0]         frame_margin_q;
  logic [3:0]         frame_exp_q;
  logic signed [17:0] mem_re_q [Frame];
  logic signed [17:0] mem_im_q [Frame];
  logic signed [17:0] lane_re_q [3];
  logic signed [17:0] lane_im_q [3];
  logic               out_val_q;
  logic [1:0]         margin_q;
  logic [3:0]         exp_q;

  logic           accept;
  logic           wr_last;
  logic           rd_last;
  logic           draining;
  logic [1:0]     marg_re;
  logic [1:0]     marg_im;
  logic [1:0]     marg_smp;
  logic [1:0]     marg_new;
  logic [WrW-1:0] idx0;
  logic [WrW-1:0] idx1;
  logic [WrW-1:0] idx2;

  // Redundant sign bits below bit 17, contiguous from bit 16, saturating at 3.
  function automatic logic [1:0] sample_margin(input logic [17:0] s);
    logic [1:0] m;
    m = 2'd0;
    if (s[16] == s[17]) begin
      m = 2'd1;
      if (s[15] == s[17]) begin
        m = 2'd2;
        if (s[14] == s[17]) m = 2'd3;
      end
    end
    return m;
  endfunction

  assign accept   = in_val && in_rdy;
  assign wr_last  = (wr_cnt_q == WrW'(Frame - 1));
  assign rd_last  = (rd_cnt_q == RdW'(N_GRP - 1));
  assign draining = (state_q == StDrain);

  assign marg_re  = sample_margin(din_real);
  assign marg_im  = sample_margin(din_imag);
  assign marg_smp = (marg_re < marg_im) ? marg_re : marg_im;
  assign marg_new = (marg_smp < run_min_q) ? marg_smp : run_min_q;

  assign idx0 = WrW'(rd_cnt_q);
  assign idx1 = idx0 + WrW'(N_GRP);
  assign idx2 = idx0 + WrW'(2 * N_GRP);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StFill;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFill:  if (accept && wr_last) state_d = StDrain;
      StDrain: if (rd_last)           state_d = StFill;
      default: state_d = StFill;
    endcase
  end

  // FSM: outputs; in_rdy is forced low combinationally while reset is asserted
  always_comb begin
    in_rdy = (state_q == StFill) && rst_n;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_cnt_q       <= '0;
      rd_cnt_q       <= '0;
      run_min_q      <= 2'd3;
      frame_margin_q <= 2'd0;
      frame_exp_q    <= 4'd0;
    end else begin
      if (accept) begin
        if (wr_cnt_q == '0) frame_exp_q <= exp_in;
        if (wr_last) begin
          wr_cnt_q       <= '0;
          run_min_q      <= 2'd3;
          frame_margin_q <= marg_new;
        end else begin
          wr_cnt_q  <= wr_cnt_q + 1'b1;
          run_min_q <= marg_new;
        end
      end
      if (draining) rd_cnt_q <= rd_last ? '0 : rd_cnt_q + 1'b1;
    end
  end

  // Sample storage needs no reset: a frame is only read after it has been fully written.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_re_q[wr_cnt_q] <= din_real;
      mem_im_q[wr_cnt_q] <= din_imag;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_val_q <= 1'b0;
      margin_q  <= 2'd0;
      exp_q     <= 4'd0;
      for (int l = 0; l < 3; l++) begin
        lane_re_q[l] <= '0;
        lane_im_q[l] <= '0;
      end
    end else begin
      out_val_q <= draining;
      if (draining) begin
        lane_re_q[0] <= mem_re_q[idx0];
        lane_re_q[1] <= mem_re_q[idx1];
        lane_re_q[2] <= mem_re_q[idx2];
        lane_im_q[0] <= mem_im_q[idx0];
        lane_im_q[1] <= mem_im_q[idx1];
        lane_im_q[2] <= mem_im_q[idx2];
        margin_q     <= frame_margin_q;
        exp_q        <= frame_exp_q;
      end
    end
  end

  always_comb begin
    out_val      = out_val_q;
    margin_out   = margin_q;
    exp_out      = exp_q;
    dout_real[0] = lane_re_q[0];
    dout_real[1] = lane_re_q[1];
    dout_real[2] = lane_re_q[2];
    dout_real[3] = '0;
    dout_real[4] = '0;
    dout_imag[0] = lane_im_q[0];
    dout_imag[1] = lane_im_q[1];
    dout_imag[2] = lane_im_q[2];
    dout_imag[3] = '0;
    dout_imag[4] = '0;
  end

endmodule

// File: tb/tb_mrd_rdx3_feeder.sv
// Bench for mrd_rdx3_feeder: a cycle-level reference model checks every output each cycle, plus
// table-driven margin frames and hand sequences for back-to-back frames and mid-drain reset.
module tb_mrd_rdx3_feeder;

  localparam int N     = 4;
  localparam int FRAME = 3 * N;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_val;
  logic               in_rdy;
  logic signed [17:0] din_real;
  logic signed [17:0] din_imag;
  logic [3:0]         exp_in;
  logic               out_val;
  logic signed [17:0] dout_real [0:4];
  logic signed [17:0] dout_imag [0:4];
  logic [1:0]         margin_out;
  logic [3:0]         exp_out;

  mrd_rdx3_feeder #(.N_GRP(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_val     (in_val),
    .in_rdy     (in_rdy),
    .din_real   (din_real),
    .din_imag   (din_imag),
    .exp_in     (exp_in),
    .out_val    (out_val),
    .dout_real  (dout_real),
    .dout_imag  (dout_imag),
    .margin_out (margin_out),
    .exp_out    (exp_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_re [FRAME];
  int m_im [FRAME];
  int m_cnt;
  int m_exp;
  int d_re [FRAME];
  int d_im [FRAME];
  int d_m;
  int d_e;
  int gq [$];
  int e_val;
  int e_re [5];
  int e_im [5];
  int e_m;
  int e_e;
  bit last_acc;

  // Observed groups of the most recent frame
  int obs_re [N][3];
  int obs_im [N][3];
  int obs_m;
  int obs_e;
  int obs_n;

  // Stimulus frame
  int fr_re [FRAME];
  int fr_im [FRAME];

  typedef struct {
    int idx;
    int re;
    int im;
    int exp_v;
    int margin;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Headroom from value range: largest m such that v fits in 18-m signed bits.
  function automatic int margin_of(input int v);
    for (int m = 3; m > 0; m--)
      if (v >= -(1 << (17 - m)) && v < (1 << (17 - m))) return m;
    return 0;
  endfunction

  task automatic model_reset();
    gq.delete();
    m_cnt = 0;
    e_val = 0;
    e_m   = 0;
    e_e   = 0;
    for (int l = 0; l < 5; l++) begin
      e_re[l] = 0;
      e_im[l] = 0;
    end
  endtask

  task automatic tick();
    bit acc;
    int k;
    int mn;
    @(posedge clk);
    acc = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else begin
      acc = in_val && (gq.size() == 0);
      if (gq.size() > 0) begin
        k = gq.pop_front();
        e_val = 1;
        for (int l = 0; l < 3; l++) begin
          e_re[l] = d_re[k + l * N];
          e_im[l] = d_im[k + l * N];
        end
        e_m = d_m;
        e_e = d_e;
      end else begin
        e_val = 0;
      end
      if (acc) begin
        if (m_cnt == 0) m_exp = int'(exp_in);
        m_re[m_cnt] = int'(din_real);
        m_im[m_cnt] = int'(din_imag);
        m_cnt++;
        if (m_cnt == FRAME) begin
          mn = 3;
          for (int i = 0; i < FRAME; i++) begin
            d_re[i] = m_re[i];
            d_im[i] = m_im[i];
            if (margin_of(m_re[i]) < mn) mn = margin_of(m_re[i]);
            if (margin_of(m_im[i]) < mn) mn = margin_of(m_im[i]);
          end
          d_m = mn;
          d_e = m_exp;
          for (int g = 0; g < N; g++) gq.push_back(g);
          m_cnt = 0;
        end
      end
    end
    last_acc = acc;
    #1;
    chk("out_val", int'(out_val), e_val);
    chk("in_rdy", int'(in_rdy), int'((gq.size() == 0) && rst_n));
    for (int l = 0; l < 5; l++) begin
      chk($sformatf("dout_real[%0d]", l), int'(dout_real[l]), e_re[l]);
      chk($sformatf("dout_imag[%0d]", l), int'(dout_imag[l]), e_im[l]);
    end
    chk("margin_out", int'(margin_out), e_m);
    chk("exp_out", int'(exp_out), e_e);
    if (out_val && obs_n < N) begin
      for (int l = 0; l < 3; l++) begin
        obs_re[obs_n][l] = int'(dout_real[l]);
        obs_im[obs_n][l] = int'(dout_imag[l]);
      end
      obs_m = int'(margin_out);
      obs_e = int'(exp_out);
      obs_n++;
    end
  endtask

  // Present fr_* in order; hold each sample until the model sees it accepted.
  task automatic send_frame(input int exp_v, input bit gaps);
    int guard;
    for (int i = 0; i < FRAME; i++) begin
      guard = 0;
      do begin
        in_val = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        if (in_val) begin
          din_real = 18'(fr_re[i]);
          din_imag = 18'(fr_im[i]);
        end else begin
          din_real = 18'($urandom);
          din_imag = 18'($urandom);
        end
        exp_in = (i == 0) ? 4'(exp_v) : 4'($urandom);
        tick();
        guard++;
      end while (!last_acc && guard < 200);
      if (!last_acc) begin
        n_checks++;
        n_errors++;
        $display("FAIL accept_timeout: sample %0d not accepted within %0d cycles", i, guard);
        in_val = 1'b0;
        return;
      end
    end
    in_val = 1'b0;
  endtask

  task automatic drain();
    in_val = 1'b0;
    repeat (N + 2) tick();
  endtask

  initial begin
    tbl[0] = '{idx: 3,  re: 131071, im: 0,       exp_v: 2,  margin: 0};
    tbl[1] = '{idx: 5,  re: 40000,  im: 0,       exp_v: 9,  margin: 1};
    tbl[2] = '{idx: 0,  re: -32768, im: 0,       exp_v: 15, margin: 2};
    tbl[3] = '{idx: 11, re: 40000,  im: 0,       exp_v: 1,  margin: 1};
    tbl[4] = '{idx: 7,  re: 0,      im: -131072, exp_v: 7,  margin: 0};
    tbl[5] = '{idx: 2,  re: 16383,  im: -16384,  exp_v: 0,  margin: 3};
    tbl[6] = '{idx: 9,  re: 16384,  im: 0,       exp_v: 12, margin: 2};

    rst_n    = 1'b0;
    in_val   = 1'b1;
    din_real = '0;
    din_imag = '0;
    exp_in   = 4'd0;
    obs_n    = 0;
    m_exp    = 0;
    model_reset();
    repeat (3) tick();
    rst_n  = 1'b1;
    in_val = 1'b0;
    tick();

    // Ramp frame with explicit group contents
    for (int i = 0; i < FRAME; i++) begin
      fr_re[i] = i * 256;
      fr_im[i] = -i;
    end
    obs_n = 0;
    send_frame(5, 1'b0);
    drain();
    chk("ramp_groups", obs_n, N);
    for (int k = 0; k < N; k++) begin
      chk("ramp_lane0", obs_re[k][0], k * 256);
      chk("ramp_lane1", obs_re[k][1], (k + 4) * 256);
      chk("ramp_lane2", obs_re[k][2], (k + 8) * 256);
      chk("ramp_imag2", obs_im[k][2], -(k + 8));
    end
    chk("ramp_margin", obs_m, 3);
    chk("ramp_exp", obs_e, 5);

    // Table-driven margin frames, alternating gap-free and gappy delivery
    for (int t = 0; t < 7; t++) begin
      for (int i = 0; i < FRAME; i++) begin
        fr_re[i] = 0;
        fr_im[i] = 0;
      end
      fr_re[tbl[t].idx] = tbl[t].re;
      fr_im[tbl[t].idx] = tbl[t].im;
      obs_n = 0;
      send_frame(tbl[t].exp_v, 1'(t % 2));
      drain();
      chk("tbl_groups", obs_n, N);
      chk("tbl_margin", obs_m, tbl[t].margin);
      chk("tbl_exp", obs_e, tbl[t].exp_v);
      chk("tbl_sample", obs_re[tbl[t].idx % N][tbl[t].idx / N], tbl[t].re);
    end

    // Random frames with 50% in_val gaps
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < FRAME; i++) begin
        fr_re[i] = int'($urandom) >>> $urandom_range(14, 19);
        fr_im[i] = int'($urandom) >>> $urandom_range(14, 19);
      end
      send_frame(int'($urandom_range(0, 15)), 1'b1);
    end
    drain();

    // Three frames with in_val held high throughout
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < FRAME; i++) begin
        fr_re[i] = (f * 100 + i) * 7;
        fr_im[i] = -(f * 100 + i);
      end
      send_frame(f + 10, 1'b0);
    end
    drain();

    // Reset pulse in the second drain cycle, then a clean frame
    for (int i = 0; i < FRAME; i++) begin
      fr_re[i] = 1000 + i;
      fr_im[i] = -2000 - i;
    end
    send_frame(3, 1'b0);
    tick();
    rst_n = 1'b0;
    tick();
    chk("rst_out_val", int'(out_val), 0);
    chk("rst_lane0", int'(dout_real[0]), 0);
    rst_n = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      fr_re[i] = 50 * i - 300;
      fr_im[i] = 40000 - i;
    end
    obs_n = 0;
    send_frame(6, 1'b1);
    drain();
    chk("post_rst_groups", obs_n, N);
    chk("post_rst_first", obs_re[0][0], -300);
    chk("post_rst_margin", obs_m, 1);
    chk("post_rst_exp", obs_e, 6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
